// File: rtl/pi_digit_reader.sv
// Streams the decimal expansion of the latched L-limb fixed-point sum: the integer digit,
// then DIGITS fraction digits obtained by repeated multiply-by-10, one limb per cycle.
module pi_digit_reader #(
  parameter int L      = 10,
  parameter int N      = 10,
  parameter int DIGITS = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [L*N-1:0]   sum,
  output logic             busy,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic [3:0]       digit,
  output logic [7:0]       dig_idx,
  output logic             dig_last,
  output logic             done,
  output logic             int_err
);

  localparam int KW = (L > 2) ? $clog2(L - 1) : 1;

  typedef enum logic [2:0] {IDLE, EMIT_INT, MUL, EMIT, FIN} state_t;

  state_t         state, nxt;
  logic [N-1:0]   w [L-1];
  logic [N-1:0]   ilimb;
  logic [KW-1:0]  k;
  logic [3:0]     carry;
  logic [N+3:0]   p;
  logic           xfer;
  logic           mul_last;

  assign xfer     = dig_valid & dig_ready;
  assign mul_last = (k == KW'(L - 2));
  // carry <= 9 always holds, so N+4 bits never overflow
  assign p        = (N+4)'(w[k]) * (N+4)'(10) + (N+4)'(carry);

  // Outputs decode only registered state, so dig_ready never reaches dig_valid.
  assign busy      = (state != IDLE);
  assign dig_valid = (state == EMIT_INT) || (state == EMIT);
  assign dig_last  = (state == EMIT) && (dig_idx == 8'(DIGITS));
  assign done      = (state == FIN);
  always_comb begin
    digit = 4'd0;
    if (state == EMIT_INT)  digit = int_err ? 4'hF : ilimb[3:0];
    else if (state == EMIT) digit = carry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (start) nxt = EMIT_INT;
      EMIT_INT: if (xfer) nxt = MUL;
      MUL:      if (mul_last) nxt = EMIT;
      EMIT:     if (xfer) nxt = dig_last ? FIN : MUL;
      FIN:      nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ilimb   <= '0;
      k       <= '0;
      carry   <= '0;
      dig_idx <= '0;
      int_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ilimb   <= sum[N*(L-1) +: N];
          int_err <= (sum[N*(L-1) +: N] >= N'(10));
          dig_idx <= '0;
        end
        EMIT_INT: if (xfer) begin
          k       <= '0;
          carry   <= '0;
          dig_idx <= 8'd1;
        end
        MUL: begin
          carry <= p[N+3:N];
          k     <= k + 1'b1;
        end
        EMIT: if (xfer && !dig_last) begin
          dig_idx <= dig_idx + 8'd1;
          k       <= '0;
          carry   <= '0;
        end
        default: ;
      endcase
    end
  end

  // Working buffer needs no reset: every run reloads it before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int i = 0; i < L-1; i++) w[i] <= sum[N*i +: N];
    end else if (state == MUL) begin
      w[k] <= p[N-1:0];
    end
  end

endmodule
